// File: rtl/alu_md_control_unit.sv
// ALU control decode plus iterative RV32M multiply/divide engine.
// Latency: alu_sel/md_sel are combinational; an M op is accepted at edge E0 and md_done pulses in the cycle after E0+XLEN (after E0 for fast specials).
// Backpressure: md_stall holds the PC/pipeline while an M op is presented and not yet done; flush or rst aborts it with no result.
//
// Ports:
//   clk, rst              core clock, synchronous active-high reset
//   alu_op, funct3,       instruction decode inputs from the main control unit
//   funct7_5, funct7_0,
//   is_rtype, instr_valid
//   flush                 abort any in-flight M op, block accept this cycle
//   rs1_val, rs2_val      operands (sampled only on accept)
//   alu_sel               4-bit ALU select
//   md_sel                writeback mux selects md_result
//   md_stall              hold PC / regfile write this cycle
//   md_done, md_result    one-cycle pulse with the M op result
module alu_md_control_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            is_rtype,
  input  logic            instr_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      alu_sel,
  output logic            md_sel,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [XLEN-1:0] opnd_q;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [1:0]      f3_q;       // low funct3 bits select result half / quotient vs remainder
  logic            neg_res_q;  // negate product or quotient
  logic            neg_rem_q;  // negate remainder (sign of dividend)
  logic            div_zero_q;

  logic md_op;
  assign md_op    = (alu_op == 2'b10) & is_rtype & funct7_0;
  assign md_sel   = md_op;
  assign md_stall = instr_valid & md_op & ~md_done;

  // ---------------- ALU select decode ----------------
  always_comb begin
    alu_sel = 4'b0000;
    if (!md_op) begin
      case (alu_op)
        2'b00: alu_sel = 4'b0000;
        2'b01: alu_sel = 4'b0001;
        2'b11: alu_sel = 4'b0011;
        default: begin
          case (funct3)
            3'b000: alu_sel = (is_rtype & funct7_5) ? 4'b0001 : 4'b0000; // imm[10] must not turn ADDI into SUB
            3'b001: alu_sel = 4'b1001;
            3'b010: alu_sel = 4'b1101;
            3'b011: alu_sel = 4'b1111;
            3'b100: alu_sel = 4'b0111;
            3'b101: alu_sel = funct7_5 ? 4'b1010 : 4'b1000;
            3'b110: alu_sel = 4'b0100;
            default: alu_sel = 4'b0101;
          endcase
        end
      endcase
    end
  end

  // ---------------- accept-time operand preparation ----------------
  logic            op_is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, special_result;
  logic            div_zero_in, div_ovf_in, fast_special;

  assign op_is_div = funct3[2];
  // MUL/MULH: s*s, MULHSU: s*u, MULHU: u*u; DIV/REM signed, DIVU/REMU unsigned
  assign a_signed  = op_is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed  = op_is_div ? ~funct3[0] : ~funct3[1];
  assign a_neg     = a_signed & rs1_val[XLEN-1];
  assign b_neg     = b_signed & rs2_val[XLEN-1];
  assign a_mag     = a_neg ? (~rs1_val + 1'b1) : rs1_val;
  assign b_mag     = b_neg ? (~rs2_val + 1'b1) : rs2_val;

  assign div_zero_in  = (rs2_val == '0);
  assign div_ovf_in   = ~funct3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_val);
  assign fast_special = FAST_SPECIAL & op_is_div & (div_zero_in | div_ovf_in);

  always_comb begin
    if (div_zero_in) special_result = funct3[1] ? rs1_val : '1;
    else             special_result = funct3[1] ? '0 : rs1_val;   // overflow: quotient is rs1 (most negative)
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_prod;
  logic [XLEN:0]     rem_sh;
  logic              fits;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s, mul_res, div_res;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign fits     = (rem_sh >= {1'b0, opnd_q});
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign div_next = {(fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], fits};

  // Final sign correction is computed from the last step's value so the
  // result register loads on the same edge that enters DONE.
  assign mul_prod = neg_res_q ? (~mul_next + 1'b1) : mul_next;
  assign mul_res  = (f3_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  assign quo     = div_next[XLEN-1:0];
  assign rem     = div_next[2*XLEN-1:XLEN];
  assign quo_s   = neg_res_q ? (~quo + 1'b1) : quo;
  assign rem_s   = neg_rem_q ? (~rem + 1'b1) : rem;
  assign div_res = f3_q[1] ? rem_s : (div_zero_q ? '1 : quo_s);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      md_done    <= 1'b0;
      md_result  <= '0;
      acc        <= '0;
      cnt        <= '0;
      opnd_q     <= '0;
      f3_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (flush) begin
      state   <= S_IDLE;
      md_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          md_done <= 1'b0;
          if (instr_valid & md_op) begin
            f3_q       <= funct3[1:0];
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= div_zero_in;
            cnt        <= CW'(XLEN-1);
            if (fast_special) begin
              state     <= S_DONE;
              md_done   <= 1'b1;
              md_result <= special_result;
            end else if (op_is_div) begin
              acc    <= {{XLEN{1'b0}}, a_mag};
              opnd_q <= b_mag;
              state  <= S_DIV;
            end else begin
              acc    <= {{XLEN{1'b0}}, b_mag};
              opnd_q <= a_mag;
              state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= S_DONE;
            md_done   <= 1'b1;
            md_result <= mul_res;
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= S_DONE;
            md_done   <= 1'b1;
            md_result <= div_res;
          end
        end
        default: begin
          md_done <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_control_unit.sv
// Self-checking bench for alu_md_control_unit: a 32-bit FAST_SPECIAL=1 instance
// and a 16-bit FAST_SPECIAL=0 instance share decode inputs, each with its own
// instr_valid. Results are compared against an arithmetic reference model.
module tb_alu_md_control_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        f7_5, f7_0, is_rtype;
  logic        iv32, iv16;
  logic [31:0] rs1, rs2;

  logic [3:0]  sel32, sel16;
  logic        msel32, msel16, st32, st16, dn32, dn16;
  logic [31:0] res32;
  logic [15:0] res16;

  int checks = 0;
  int failures = 0;

  alu_md_control_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut32 (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct3(funct3), .funct7_5(f7_5),
    .funct7_0(f7_0), .is_rtype(is_rtype), .instr_valid(iv32), .flush(flush),
    .rs1_val(rs1), .rs2_val(rs2), .alu_sel(sel32), .md_sel(msel32),
    .md_stall(st32), .md_done(dn32), .md_result(res32));

  alu_md_control_unit #(.XLEN(16), .FAST_SPECIAL(1'b0)) dut16 (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct3(funct3), .funct7_5(f7_5),
    .funct7_0(f7_0), .is_rtype(is_rtype), .instr_valid(iv16), .flush(flush),
    .rs1_val(rs1[15:0]), .rs2_val(rs2[15:0]), .alu_sel(sel16), .md_sel(msel16),
    .md_stall(st16), .md_done(dn16), .md_result(res16));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ALU select table
  function automatic logic [3:0] exp_sel(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f75, input logic rt, input logic f70);
    if (op == 2'b10 && rt && f70) return 4'd0;
    case (op)
      2'b00: return 4'd0;
      2'b01: return 4'd1;
      2'b11: return 4'd3;
      default: begin
        case (f3)
          3'd0: return (rt && f75) ? 4'd1 : 4'd0;
          3'd1: return 4'd9;
          3'd2: return 4'd13;
          3'd3: return 4'd15;
          3'd4: return 4'd7;
          3'd5: return f75 ? 4'd10 : 4'd8;
          3'd6: return 4'd4;
          default: return 4'd5;
        endcase
      end
    endcase
  endfunction

  // RV32M reference at width w using 64-bit integer arithmetic
  function automatic logic [31:0] mref(input int w, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
    longint m    = (longint'(1) << w) - 1;
    longint minv = -(longint'(1) << (w - 1));
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
    longint sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
    longint r;
    logic [63:0] pu;
    bit ovf = (sa == minv) && (sb == -1);
    case (f3)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: begin pu = ua * ub; r = longint'(pu >> w); end
      3'd4: r = (ub == 0) ? m : (ovf ? minv : sa / sb);
      3'd5: r = (ub == 0) ? m : ua / ub;
      3'd6: r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & m);
  endfunction

  // Present one M op to the chosen instance at a negedge, hold it until done,
  // toggling operands while it runs. Returns at the negedge after md_done.
  task automatic run_mop(input int w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    logic [31:0] exp = mref(w, f3, a, b);
    bit spec = (w == 32) && f3[2] &&
               (((b & m) == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    int lat = spec ? 2 : w + 2;
    int n = 1;
    bit done = 0;
    alu_op = 2'b10; funct3 = f3; f7_5 = 1'b0; f7_0 = 1'b1; is_rtype = 1'b1;
    rs1 = a; rs2 = b;
    if (w == 32) iv32 = 1'b1; else iv16 = 1'b1;
    while (!done && n <= w + 8) begin
      #1;
      if ((w == 32) ? dn32 : dn16) begin
        done = 1;
      end else begin
        if (n == 1 || n == lat - 1)
          check($sformatf("stall_w%0d_f%0d_c%0d", w, f3, n), (w == 32) ? st32 : st16, 1);
        @(posedge clk);
        @(negedge clk);
        n++;
        rs1 = $urandom;
        rs2 = $urandom;
      end
    end
    check($sformatf("done_seen_w%0d_f%0d", w, f3), 64'(done), 1);
    check($sformatf("latency_w%0d_f%0d", w, f3), 64'(n), 64'(lat));
    check($sformatf("result_w%0d_f%0d_a%0h_b%0h", w, f3, a, b),
          (w == 32) ? res32 : {16'h0, res16}, exp);
    check($sformatf("stall_at_done_w%0d", w), (w == 32) ? st32 : st16, 0);
    @(negedge clk);
    iv32 = 1'b0;
    iv16 = 1'b0;
  endtask

  // Start a DIV, kill it mid-iteration with flush or rst, confirm no result.
  task automatic run_abort(input bit use_rst);
    int pulses = 0;
    alu_op = 2'b10; funct3 = 3'd4; f7_5 = 1'b0; f7_0 = 1'b1; is_rtype = 1'b1;
    rs1 = 32'd1000; rs2 = 32'd7; iv32 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    iv32 = 1'b0;
    #1 check(use_rst ? "abort_rst_stall" : "abort_flush_stall", st32, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1 if (dn32) pulses++;
      @(negedge clk);
    end
    check(use_rst ? "abort_rst_no_done" : "abort_flush_no_done", 64'(pulses), 0);
    if (use_rst) check("abort_rst_result_cleared", res32, 0);
    run_mop(32, 3'd3, 32'hFFFF_FFFF, 32'd3);
  endtask

  logic [2:0]  d_f3 [17] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd2,
                             3'd0, 3'd4, 3'd5, 3'd4, 3'd6};
  logic [31:0] d_a  [17] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'd7, 32'hFFF9, 32'd100, 32'd5, 32'h8000};
  logic [31:0] d_b  [17] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                             32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                             32'hFFFD, 32'd2, 32'd7, 32'd0, 32'hFFFF};

  initial begin
    int pulses;
    rst = 1'b1; flush = 1'b0; alu_op = 2'b00; funct3 = 3'd0; f7_5 = 1'b0; f7_0 = 1'b0;
    is_rtype = 1'b0; iv32 = 1'b0; iv16 = 1'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_done32", dn32, 0);
    check("reset_result32", res32, 0);
    check("reset_done16", dn16, 0);
    check("reset_result16", res16, 0);
    check("reset_stall32", st32, 0);

    // Decode sweep, including instr_valid=0 with md_op=1 (no stall)
    for (int i = 0; i < 256; i++) begin
      {alu_op, funct3, f7_5, is_rtype, f7_0} = 8'(i);
      #1;
      check($sformatf("alu_sel_%02h", i), sel32, exp_sel(alu_op, funct3, f7_5, is_rtype, f7_0));
      check($sformatf("md_sel_%02h", i), msel32, 64'(alu_op == 2'b10 && is_rtype && f7_0));
      if (i[6:0] == 7'h55) check($sformatf("alu_sel16_%02h", i), sel16,
                                 exp_sel(alu_op, funct3, f7_5, is_rtype, f7_0));
      check($sformatf("no_stall_idle_%02h", i), st32, 0);
    end
    @(negedge clk);

    // Directed ops from the plan, back-to-back with mid-op operand toggling
    for (int i = 0; i < 17; i++) run_mop((i < 12) ? 32 : 16, d_f3[i], d_a[i], d_b[i]);

    // flush in IDLE blocks accept
    alu_op = 2'b10; funct3 = 3'd0; f7_0 = 1'b1; is_rtype = 1'b1; f7_5 = 1'b0;
    rs1 = 32'd3; rs2 = 32'd4; iv32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    iv32 = 1'b0; flush = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      #1 if (dn32) pulses++;
      @(negedge clk);
    end
    check("flush_idle_no_accept", 64'(pulses), 0);

    run_abort(1'b0);
    run_abort(1'b1);

    // Randomized ops, biased toward special cases
    for (int i = 0; i < 40; i++) begin
      int w = (i % 3 == 2) ? 16 : 32;
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      int mode = $urandom_range(0, 5);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = (w == 32) ? 32'h8000_0000 : 32'h8000; b = (w == 32) ? 32'hFFFF_FFFF : 32'hFFFF; end
        2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 5); end
        default: ;
      endcase
      run_mop(w, f3, a, b);
      #1 check($sformatf("done_pulse_once_%0d", i), (w == 32) ? dn32 : dn16, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
